cdr_phase_ctrl: RTL and testbench

CDR_PHASE_CTRL -- requirements
Module: cdr_phase_ctrl

---
 rtl/cdr_phase_ctrl_if.sv | 10 +
 rtl/cdr_phase_ctrl.sv | 156 +++++++++++++++
 tb/tb_cdr_phase_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdr_phase_ctrl_if.sv
// Phase-interpolator handshake bundle: code and request from the controller,
// acknowledge back from the interpolator.
interface cdr_phase_ctrl_if;
  logic [7:0] pi_code;
  logic       pi_req;
  logic       pi_ack;

  modport master (output pi_code, output pi_req, input pi_ack);
  modport slave  (input pi_code, input pi_req, output pi_ack);
endinterface

// File: rtl/cdr_phase_ctrl.sv
// CDR phase-interpolator controller: decimated, slew-limited phase updates with
// a req/ack handshake, lock detection and optional wrap counting (CDR_PHASE_WRAP_CNT_EN).
//
// state  | meaning
// IDLE   | waiting for an update opportunity
// WAIT   | pi_req raised, waiting for pi_ack or the 64-cycle timeout
module cdr_phase_ctrl (
  input  logic              clk,
  input  logic              Reset,
  input  logic signed [8:0] i_filt_in,
  input  logic              i_en,
  input  logic [1:0]        i_decim,
  input  logic [3:0]        i_max_step,
  output logic              o_lock,
  output logic              o_ack_err,
  output logic signed [7:0] o_freq_off,
  cdr_phase_ctrl_if.master  pi
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0] r_state;
  logic [2:0] r_dec_cnt;
  logic [1:0] r_decim_act;
  logic [5:0] r_wait_cnt;
  logic [4:0] r_lock_cnt;
  logic [7:0] r_pi_code;
  logic       r_pi_req;
  logic       r_ack_err;

  logic [2:0]        w_dec_max;
  logic              w_opp;
  logic              w_take;
  logic              w_update;
  logic              w_small;
  logic              w_step_nz;
  logic signed [8:0] w_raw;
  logic signed [8:0] w_max_pos;
  logic signed [8:0] w_max_neg;
  logic signed [8:0] w_step;
  logic [7:0]        w_next_code;

  // The active decimation is only reloaded at a wrap, so a decim change can
  // never produce an early or extra opportunity.
  always_comb begin
    w_dec_max = 3'd0;
    case (r_decim_act)
      2'd0: w_dec_max = 3'd0;
      2'd1: w_dec_max = 3'd1;
      2'd2: w_dec_max = 3'd3;
      default: w_dec_max = 3'd7;
    endcase
  end

  assign w_opp     = (r_dec_cnt == w_dec_max);
  assign w_raw     = i_filt_in >>> 2;
  assign w_max_pos = $signed({5'b00000, i_max_step});
  assign w_max_neg = -w_max_pos;

  always_comb begin
    w_step = w_raw;
    if (w_raw > w_max_pos)
      w_step = w_max_pos;
    else if (w_raw < w_max_neg)
      w_step = w_max_neg;
  end

  assign w_small     = (w_raw >= -9'sd1) && (w_raw <= 9'sd1);
  assign w_step_nz   = (w_step != 9'sd0);
  assign w_take      = w_opp && i_en && (r_state == S_IDLE);
  assign w_update    = w_take && w_step_nz;
  assign w_next_code = r_pi_code + w_step[7:0];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_dec_cnt   <= '0;
      r_decim_act <= '0;
      r_wait_cnt  <= '0;
      r_lock_cnt  <= '0;
      r_pi_code   <= '0;
      r_pi_req    <= 1'b0;
      r_ack_err   <= 1'b0;
    end else begin
      if (w_opp) begin
        r_dec_cnt   <= '0;
        r_decim_act <= i_decim;
      end else begin
        r_dec_cnt <= r_dec_cnt + 3'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_update) begin
            r_pi_code  <= w_next_code;
            r_pi_req   <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Ack wins over a timeout landing on the same edge.
          if (pi.pi_ack) begin
            r_pi_req <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_wait_cnt == 6'd63) begin
            r_pi_req  <= 1'b0;
            r_ack_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 6'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (!i_en)
        r_lock_cnt <= '0;
      else if (w_take) begin
        if (!w_small)
          r_lock_cnt <= '0;
        else if (r_lock_cnt != 5'd16)
          r_lock_cnt <= r_lock_cnt + 5'd1;
      end
    end
  end

`ifdef CDR_PHASE_WRAP_CNT_EN
  logic signed [9:0] w_sum;
  logic signed [7:0] r_freq_off;

  assign w_sum = $signed({2'b00, r_pi_code}) + {w_step[8], w_step};

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_freq_off <= '0;
    end else if (w_update) begin
      if ((w_sum > 10'sd255) && (r_freq_off != 8'sh7F))
        r_freq_off <= r_freq_off + 8'sd1;
      else if ((w_sum < 10'sd0) && (r_freq_off != 8'sh80))
        r_freq_off <= r_freq_off - 8'sd1;
    end
  end

  assign o_freq_off = r_freq_off;
`else
  assign o_freq_off = '0;
`endif

  assign pi.pi_code = r_pi_code;
  assign pi.pi_req  = r_pi_req;
  assign o_lock     = (r_lock_cnt == 5'd16);
  assign o_ack_err  = r_ack_err;

endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// Bench for cdr_phase_ctrl: directed scenarios plus randomized traffic against an
// arithmetic reference model, with a scoreboard checking every new phase request.
module tb_cdr_phase_ctrl;

  logic              clk = 1'b0;
  logic              Reset;
  logic signed [8:0] filt;
  logic              en;
  logic [1:0]        decim;
  logic [3:0]        max_step;
  logic              lock;
  logic              ack_err;
  logic signed [7:0] freq_off;

  cdr_phase_ctrl_if pi_if ();

  cdr_phase_ctrl dut (
    .clk        (clk),
    .Reset      (Reset),
    .i_filt_in  (filt),
    .i_en       (en),
    .i_decim    (decim),
    .i_max_step (max_step),
    .o_lock     (lock),
    .o_ack_err  (ack_err),
    .o_freq_off (freq_off),
    .pi         (pi_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int code; int fo; int lk;} exp_t;
  exp_t sb_q[$];

  // stimulus controls applied before each rising edge
  int c_filt, c_en, c_decim, c_max, ack_delay;
  bit rand_ack = 1'b0;

  // reference model state (after the most recent rising edge)
  int m_cnt, m_dlog, m_busy, m_age, m_err, m_lock, m_phase, m_fo, m_updates;
  int run_len, last_run;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic int floor_div4(input int f);
    return (f >= 0) ? f / 4 : -((-f + 3) / 4);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_dlog = 0; m_busy = 0; m_age = 0; m_err = 0;
    m_lock = 0; m_phase = 0; m_fo = 0; run_len = 0;
  endtask

  // One rising edge of the specified behaviour, using the inputs just driven.
  task automatic model_step();
    int busy_pre, raw, step, sum;
    bit opp;
    exp_t e;
    busy_pre = m_busy;
    if (m_busy != 0) begin
      if (pi_if.pi_ack) m_busy = 0;
      else if (m_age + 1 == 64) begin m_busy = 0; m_err = 1; end
      else m_age++;
    end
    opp = (m_cnt + 1 == (1 << m_dlog));
    if (opp) begin m_cnt = 0; m_dlog = c_decim; end
    else m_cnt++;
    if (opp && c_en != 0 && busy_pre == 0) begin
      raw  = floor_div4(c_filt);
      step = (raw > c_max) ? c_max : ((raw < -c_max) ? -c_max : raw);
      if (raw >= -1 && raw <= 1) m_lock = (m_lock < 16) ? m_lock + 1 : 16;
      else m_lock = 0;
      if (step != 0) begin
        sum = m_phase + step;
`ifdef CDR_PHASE_WRAP_CNT_EN
        if (sum > 255 && m_fo < 127) m_fo++;
        if (sum < 0 && m_fo > -128) m_fo--;
`endif
        m_phase = (sum + 256) % 256;
        m_busy = 1; m_age = 0; m_updates++;
        e.code = m_phase; e.fo = m_fo; e.lk = (m_lock == 16) ? 1 : 0;
        sb_q.push_back(e);
        if (rand_ack) begin
          case ($urandom_range(0, 9))
            6: ack_delay = 63;
            7: ack_delay = 62;
            8, 9: ack_delay = 64 + int'($urandom_range(0, 3));
            default: ack_delay = int'($urandom_range(0, 4));
          endcase
        end
      end
    end
    if (c_en == 0) m_lock = 0;
  endtask

  task automatic prep();
    filt     = 9'(c_filt);
    en       = c_en[0];
    decim    = 2'(c_decim);
    max_step = 4'(c_max);
    if (m_busy != 0) pi_if.pi_ack = (m_age == ack_delay);
    else pi_if.pi_ack = ($urandom_range(0, 3) == 0);
    model_step();
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("pi_req", int'(pi_if.pi_req), m_busy);
    chk("pi_code", int'(pi_if.pi_code), m_phase);
    chk("lock", int'(lock), (m_lock == 16) ? 1 : 0);
    chk("ack_err", int'(ack_err), m_err);
    chk("freq_off", int'(freq_off), m_fo);
    if (pi_if.pi_req) run_len++;
    else if (run_len > 0) begin last_run = run_len; run_len = 0; end
    prep();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_code"}, int'(pi_if.pi_code), 0);
    chk({nm, "_req"}, int'(pi_if.pi_req), 0);
    chk({nm, "_lock"}, int'(lock), 0);
    chk({nm, "_ack_err"}, int'(ack_err), 0);
    chk({nm, "_freq_off"}, int'(freq_off), 0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #2 Reset = 1'b0;
    #1 chk_all_zero(nm);
    model_reset();
    sb_q.delete();
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    prep();
  endtask

  task automatic wait_updates(input int n, input string nm);
    int target, k;
    target = m_updates + n;
    k = 0;
    while ((m_updates < target || m_busy != 0) && k < 2000) begin
      cycle();
      k++;
    end
    if (k >= 2000) chk({nm, "_timeout"}, k, -1);
  endtask

  task automatic pause();
    c_en = 0;
    cycle();
  endtask

  // scoreboard monitor: every new request must match the predicted one
  bit mon_prev_req = 1'b0;
  always @(negedge clk) begin
    if (Reset && pi_if.pi_req && !mon_prev_req) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_req_code", int'(pi_if.pi_code), -1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_code", int'(pi_if.pi_code), e.code);
        chk("sb_freq_off", int'(freq_off), e.fo);
        chk("sb_lock", int'(lock), e.lk);
      end
    end
    mon_prev_req = pi_if.pi_req;
  end

  int fo0, k;

  initial begin
    Reset = 1'b0;
    c_filt = 0; c_en = 0; c_decim = 0; c_max = 0; ack_delay = 1;
    filt = '0; en = 1'b0; decim = '0; max_step = '0; pi_if.pi_ack = 1'b0;
    m_updates = 0; last_run = 0;
    model_reset();
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    prep();

    // +20 -> step 5 per update
    c_en = 1; c_decim = 0; c_max = 15; c_filt = 20; ack_delay = 1;
    wait_updates(3, "basic");
    pause();
    chk("basic_code", int'(pi_if.pi_code), 15);

    // slew limit both directions
    c_en = 1; c_max = 4; c_filt = 200;
    wait_updates(2, "slew_pos");
    pause();
    chk("slew_pos_code", int'(pi_if.pi_code), 23);
    c_en = 1; c_filt = -200;
    wait_updates(2, "slew_neg");
    pause();
    chk("slew_neg_code", int'(pi_if.pi_code), 15);

    // wrap 254 -> 2
    do_reset("reset2");
    c_en = 1; c_max = 15; c_filt = -8;
    wait_updates(1, "to254");
    pause();
    chk("wrap_pre_code", int'(pi_if.pi_code), 254);
    fo0 = int'(freq_off);
    c_en = 1; c_filt = 16;
    wait_updates(1, "wrap");
    pause();
    chk("wrap_code", int'(pi_if.pi_code), 2);
`ifdef CDR_PHASE_WRAP_CNT_EN
    chk("wrap_freq_off_delta", int'(freq_off) - fo0, 1);
`else
    chk("wrap_freq_off_delta", int'(freq_off) - fo0, 0);
`endif

    // acknowledge timeout
    c_en = 1; c_filt = 4; ack_delay = 1000;
    wait_updates(1, "ack_to");
    pause();
    chk("ack_to_req_len", last_run, 64);
    chk("ack_to_err", int'(ack_err), 1);
    c_en = 1; ack_delay = 1;
    wait_updates(1, "after_to");
    pause();
    chk("after_to_code", int'(pi_if.pi_code), 4);
    chk("after_to_err_sticky", int'(ack_err), 1);

    // lock after 16 small-step opportunities, lost on a large one
    repeat (10) cycle();
    c_en = 1; c_filt = 3; c_max = 4;
    repeat (16) cycle();
    chk("lock_15", int'(lock), 0);
    cycle();
    chk("lock_16", int'(lock), 1);
    c_filt = 8;
    cycle();
    cycle();
    chk("lock_lost", int'(lock), 0);
    wait_updates(0, "lock_drain");

    // randomized traffic
    rand_ack = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        c_filt  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 14)) - 7
                                                : int'($urandom_range(0, 511)) - 256;
        c_max   = int'($urandom_range(0, 15));
        c_decim = int'($urandom_range(0, 3));
        c_en    = ($urandom_range(0, 7) != 0) ? 1 : 0;
      end
      cycle();
    end
    rand_ack = 1'b0;
    ack_delay = 1;
    c_decim = 0;
    pause();
    repeat (12) cycle();

    // asynchronous reset mid-handshake at code 0x40
    do_reset("reset3");
    c_en = 1; c_max = 15; c_filt = 60; ack_delay = 1;
    wait_updates(4, "to60");
    c_max = 4; ack_delay = 1000;
    k = 0;
    while (m_busy == 0 && k < 50) begin cycle(); k++; end
    if (k >= 50) chk("to64_timeout", k, -1);
    cycle();
    chk("midhs_req", int'(pi_if.pi_req), 1);
    chk("midhs_code", int'(pi_if.pi_code), 64);
    #2 Reset = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    sb_q.delete();
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    c_en = 0;
    prep();
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
